// File: rtl/param_iter_shifter.sv
// Multi-cycle parametrised barrel shifter.
// One log2 stage is evaluated per clock, so every operation takes exactly
// SHAMT_W cycles in SHIFT regardless of the shift amount. Supports SLL, SRL,
// SRA, ROL and ROR; modes 101-111 pass the operand through and raise out_err.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds its data stable while valid is high and
// ready is low; ready never depends combinationally on the other side's valid.
// in_ready is high only in IDLE and out_valid only in DONE, so the block
// never accepts a new operation in the same cycle a result leaves.
//
// The FSM state is kept in the named enum register 'state'. Its encoding is
// fixed so that checkers can bind to it directly.
module param_iter_shifter #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [2:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_zero,
    output logic               out_err
);

    // Stage counter only has to reach SHAMT_W-1.
    localparam int CNT_W = $clog2(SHAMT_W + 1);

    // Shift distances are at most WIDTH/2, so SHAMT_W+1 bits hold both
    // the distance and WIDTH itself for the rotate complement.
    localparam logic [SHAMT_W:0] ONE_L   = (SHAMT_W+1)'(1);
    localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W+1)'(WIDTH);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   data_r;
    logic [SHAMT_W-1:0] b_r;        // shifted right each stage: b_r[0] is the current bit
    logic [2:0]         mode_r;
    logic               sign_r;     // captured operand MSB, used as the SRA fill
    logic [CNT_W-1:0]   stage_cnt;

    logic [WIDTH-1:0]   out_r;
    logic               out_zero_r;
    logic               out_err_r;

    logic [SHAMT_W:0]   amt;
    logic [WIDTH-1:0]   stage_val;
    logic [WIDTH-1:0]   stage_res;
    logic               last_stage;
    logic               mode_illegal;

    assign last_stage   = (stage_cnt == CNT_W'(SHAMT_W - 1));
    assign mode_illegal = (mode_r > MODE_ROR);

    assign out      = out_r;
    assign out_zero = out_zero_r;
    assign out_err  = out_err_r;

    // One stage of 2^stage_cnt in the captured mode; held when the amount bit is 0.
    always_comb begin
        amt       = ONE_L << stage_cnt;
        stage_val = data_r;
        case (mode_r)
            MODE_SLL: stage_val = data_r << amt;
            MODE_SRL: stage_val = data_r >> amt;
            MODE_SRA: stage_val = (data_r >> amt) |
                                  (sign_r ? ~({WIDTH{1'b1}} >> amt) : '0);
            MODE_ROL: stage_val = (data_r << amt) | (data_r >> (WIDTH_L - amt));
            MODE_ROR: stage_val = (data_r >> amt) | (data_r << (WIDTH_L - amt));
            default:  stage_val = data_r;
        endcase
        stage_res = b_r[0] ? stage_val : data_r;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_stage) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-stage shifting and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r     <= '0;
            b_r        <= '0;
            mode_r     <= '0;
            sign_r     <= 1'b0;
            stage_cnt  <= '0;
            out_r      <= '0;
            out_zero_r <= 1'b0;
            out_err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r    <= a;
                        b_r       <= b;
                        mode_r    <= mode;
                        sign_r    <= a[WIDTH-1];
                        stage_cnt <= '0;
                    end
                end
                SHIFT: begin
                    data_r    <= stage_res;
                    b_r       <= b_r >> 1;
                    stage_cnt <= last_stage ? '0 : stage_cnt + CNT_W'(1);
                    if (last_stage) begin
                        out_r      <= stage_res;
                        out_zero_r <= (stage_res == '0);
                        out_err_r  <= mode_illegal;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_iter_shifter.sv
// Testbench for param_iter_shifter: directed vectors on a 32-bit instance
// through an expected-result queue, plus a small 8-bit instance.
module tb_param_iter_shifter;

    localparam int W  = 32;
    localparam int SW = 5;
    localparam int EW = W + 2;   // {err, zero, out}

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 32-bit DUT ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [SW-1:0] b = '0;
    logic [2:0]    mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;
    logic          out_zero;
    logic          out_err;

    param_iter_shifter #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_zero(out_zero), .out_err(out_err)
    );

    // ---------------- 8-bit DUT ----------------
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_a = '0;
    logic [2:0] s_b = '0;
    logic [2:0] s_mode = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [7:0] s_out;
    logic       s_out_zero;
    logic       s_out_err;

    param_iter_shifter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .mode(s_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out(s_out), .out_zero(s_out_zero), .out_err(s_out_err)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every result that leaves through the output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_result", {out_err, out_zero, out}, '0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check({out_err, out_zero, out} == e, "result",
                      {out_err, out_zero, out}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] ia, input logic [SW-1:0] ib,
                         input logic [2:0] im, input logic [W-1:0] eo,
                         input bit ee);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(in_ready, "in_ready_wait", in_ready, 1);
        a = ia; b = ib; mode = im; in_valid = 1'b1;
        exp_q.push_back({ee, (eo == '0), eo});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands are free to change once captured.
        a    = $urandom;
        b    = SW'($urandom_range(0, 31));
        mode = 3'($urandom_range(0, 7));
    endtask

    // Issue, then check latency and the in_ready busy window (out_ready=1).
    task automatic run_op(input logic [W-1:0] ia, input logic [SW-1:0] ib,
                          input logic [2:0] im, input logic [W-1:0] eo,
                          input bit ee);
        int lat;
        int busy;
        bit seen;
        lat = -1; busy = 0; seen = 1'b0;
        issue(ia, ib, im, eo, ee);
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (!in_ready) busy++;
            if (out_valid) begin
                seen = 1'b1;
                lat  = i - 1;
            end
        end
        check(lat == SW, "latency", lat, SW);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
        end
        check(busy == SW + 1, "in_ready_low_cycles", busy, SW + 1);
    endtask

    task automatic run8(input logic [7:0] ia, input logic [2:0] ib,
                        input logic [2:0] im, input logic [7:0] eo);
        int lat;
        lat = -1;
        @(negedge clk);
        s_a = ia; s_b = ib; s_mode = im; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_a = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (s_out_valid) begin
                lat = i - 1;
                break;
            end
        end
        check(lat == 3, "w8_latency", lat, 3);
        check(s_out == eo, "w8_out", s_out, eo);
        check(s_out_err == 1'b0, "w8_err", s_out_err, 0);
        check(s_out_zero == (eo == 8'h00), "w8_zero", s_out_zero, (eo == 8'h00));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] held;
        int t;

        #12;
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        check(out == '0, "reset_out", out, 0);
        check(out_zero == 1'b0, "reset_out_zero", out_zero, 0);
        check(out_err == 1'b0, "reset_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        run_op(32'h0000_0001, 5'd31, SLL, 32'h8000_0000, 1'b0);
        run_op(32'h8000_00F0, 5'd4,  SRL, 32'h0800_000F, 1'b0);
        run_op(32'h8000_00F0, 5'd4,  SRA, 32'hF800_000F, 1'b0);
        run_op(32'h8000_00F0, 5'd4,  ROR, 32'h0800_000F, 1'b0);
        run_op(32'h8000_00F0, 5'd4,  ROL, 32'h0000_0F08, 1'b0);
        run_op(32'hDEAD_BEEF, 5'd0,  ROL, 32'hDEAD_BEEF, 1'b0);
        run_op(32'h0000_0001, 5'd1,  SRL, 32'h0000_0000, 1'b0);
        run_op(32'h1234_5678, 5'd7,  3'b110, 32'h1234_5678, 1'b1);
        run_op(32'h1234_5678, 5'd8,  SLL, 32'h3456_7800, 1'b0);
        run_op(32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h0000_0001, 5'd1,  ROR, 32'h8000_0000, 1'b0);
        run_op(32'hCAFE_0000, 5'd3,  3'b111, 32'hCAFE_0000, 1'b1);
        run_op(32'h4000_0000, 5'd3,  SRA, 32'h0800_0000, 1'b0);

        // Backpressure: hold the result in DONE for 10 cycles.
        out_ready = 1'b0;
        issue(32'h1234_5678, 5'd16, ROR, 32'h5678_1234, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(out_valid, "bp_reach_done", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check(out_valid && !in_ready && out == 32'h5678_1234, "bp_hold",
                  {out_valid, in_ready, out}, {2'b10, 32'h5678_1234});
            if (i == 3) begin
                a = 32'hFFFF_FFFF; b = 5'd1; mode = SLL; in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);   // monitor takes the result here
        @(negedge clk);
        check(in_ready == 1'b1, "bp_idle_ready", in_ready, 1);
        check(out_valid == 1'b0, "bp_idle_valid", out_valid, 0);
        check(out == 32'h5678_1234, "bp_out_held", out, 32'h5678_1234);
        repeat (3) @(negedge clk);
        check(in_ready == 1'b1, "bp_pulse_ignored", in_ready, 1);

        // Reset in the middle of SHIFT (stage 2).
        issue(32'h0000_00FF, 5'd31, SLL, 32'h8000_0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check(out_valid == 1'b0, "rst_mid_out_valid", out_valid, 0);
        check(in_ready == 1'b1, "rst_mid_in_ready", in_ready, 1);
        check(out == '0, "rst_mid_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0F0F_0F0F, 5'd12, ROL, 32'hF0F0_F0F0, 1'b0);
        run_op(32'hFFFF_FFFF, 5'd31, SRL, 32'h0000_0001, 1'b0);

        // Narrow instance.
        run8(8'h81, 3'd3, ROL, 8'h0C);
        run8(8'h81, 3'd7, SRA, 8'hFF);
        run8(8'h81, 3'd1, ROR, 8'hC0);

        repeat (4) @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
